// File: rtl/ecg_peak_detector_if.sv
// Sample/result bundle for ecg_peak_detector: the filtered sample stream enters
// and peak reports come back; master is the producer/consumer, slave the detector.
interface ecg_peak_detector_if #(
  parameter int DATA_W = 16,
  parameter int RR_W   = 16
);
  logic signed [DATA_W-1:0] sample_in;
  logic                     sample_valid;
  logic                     peak_valid;
  logic signed [DATA_W-1:0] peak_amp;
  logic        [RR_W-1:0]   rr_interval;
  logic                     rr_first;
  logic signed [DATA_W-1:0] threshold;
  logic                     busy;

  modport master (
    output sample_in, sample_valid,
    input  peak_valid, peak_amp, rr_interval, rr_first, threshold, busy
  );

  modport slave (
    input  sample_in, sample_valid,
    output peak_valid, peak_amp, rr_interval, rr_first, threshold, busy
  );
endinterface

// File: rtl/ecg_peak_detector.sv
// R-peak detector with adaptive threshold, refractory window and RR interval.
// ECG_PEAK_ABS_EN: rectify the input so inverted-lead QRS complexes are detected.
module ecg_peak_detector #(
  parameter int DATA_W      = 16,
  parameter int RR_W        = 16,
  parameter int THRESH_INIT = 2048,
  parameter int MIN_THRESH  = 512,
  parameter int REFRACT     = 72,
  parameter int MAX_WIDTH   = 32
) (
  input  logic               clk,
  input  logic               reset,
  ecg_peak_detector_if.slave bus
);
  localparam int LVL_W    = DATA_W + 2;
  localparam int SPAN_MAX = (REFRACT > MAX_WIDTH) ? REFRACT : MAX_WIDTH;
  localparam int SPAN_W   = $clog2(SPAN_MAX + 1);

  localparam logic [1:0] S_SEARCH  = 2'd0;
  localparam logic [1:0] S_TRACK   = 2'd1;
  localparam logic [1:0] S_REFRACT = 2'd2;

  localparam logic [SPAN_W-1:0]       WIDTH_LAST = SPAN_W'(MAX_WIDTH - 1);
  localparam logic [SPAN_W-1:0]       REFR_LAST  = SPAN_W'(REFRACT - 1);
  localparam logic signed [LVL_W-1:0] MIN_L      = LVL_W'(MIN_THRESH);

  logic [1:0]               state_q, state_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic [RR_W-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [RR_W-1:0]          snap_q, snap_d;
  logic [SPAN_W-1:0]        span_q, span_d;
  logic signed [LVL_W-1:0]  lvl_q, lvl_d;
  logic signed [DATA_W-1:0] thr_q, thr_d;
  logic                     first_q, first_d;
  logic                     pv_q, pv_d;
  logic signed [DATA_W-1:0] amp_q, amp_d;
  logic [RR_W-1:0]          rr_q, rr_d;
  logic                     rrf_q, rrf_d;

  logic signed [DATA_W-1:0] x;
  logic signed [LVL_W-1:0]  max_ext, lvl_next, lvl_half;
  logic signed [DATA_W-1:0] thr_next;

`ifdef ECG_PEAK_ABS_EN
  always_comb begin
    if (bus.sample_in == {1'b1, {(DATA_W-1){1'b0}}})
      x = {1'b0, {(DATA_W-1){1'b1}}};
    else if (bus.sample_in[DATA_W-1])
      x = -bus.sample_in;
    else
      x = bus.sample_in;
  end
`else
  always_comb x = bus.sample_in;
`endif

  always_comb begin
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    max_ext  = {{(LVL_W-DATA_W){max_q[DATA_W-1]}}, max_q};
    lvl_next = lvl_q - (lvl_q >>> 3) + (max_ext >>> 3);
    lvl_half = lvl_next >>> 1;
    thr_next = (lvl_half < MIN_L) ? DATA_W'(MIN_THRESH) : lvl_half[DATA_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    span_d  = span_q;
    lvl_d   = lvl_q;
    thr_d   = thr_q;
    first_d = first_q;
    pv_d    = 1'b0;
    amp_d   = amp_q;
    rr_d    = rr_q;
    rrf_d   = rrf_q;
    if (bus.sample_valid) begin
      cnt_d = cnt_inc;
      case (state_q)
        S_SEARCH: begin
          if (x > thr_q) begin
            state_d = S_TRACK;
            max_d   = x;
            snap_d  = cnt_inc;
            span_d  = '0;
          end
        end
        S_TRACK: begin
          if (x >= max_q) begin
            if (span_q == WIDTH_LAST) begin
              state_d = S_SEARCH;
            end else begin
              max_d  = x;
              snap_d = cnt_inc;
              span_d = span_q + 1'b1;
            end
          end else begin
            pv_d    = 1'b1;
            amp_d   = max_q;
            rr_d    = snap_q;
            rrf_d   = first_q;
            first_d = 1'b0;
            lvl_d   = lvl_next;
            thr_d   = thr_next;
            // The max is always the sample just before the drop, so one sample
            // has elapsed; a constant also stays correct once the counter saturates.
            cnt_d   = RR_W'(1);
            span_d  = '0;
            state_d = S_REFRACT;
          end
        end
        S_REFRACT: begin
          if (span_q == REFR_LAST) state_d = S_SEARCH;
          else                     span_d  = span_q + 1'b1;
        end
        default: state_d = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_SEARCH;
      max_q   <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      span_q  <= '0;
      lvl_q   <= LVL_W'(2 * THRESH_INIT);
      thr_q   <= DATA_W'(THRESH_INIT);
      first_q <= 1'b1;
      pv_q    <= 1'b0;
      amp_q   <= '0;
      rr_q    <= '0;
      rrf_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      span_q  <= span_d;
      lvl_q   <= lvl_d;
      thr_q   <= thr_d;
      first_q <= first_d;
      pv_q    <= pv_d;
      amp_q   <= amp_d;
      rr_q    <= rr_d;
      rrf_q   <= rrf_d;
    end
  end

  assign bus.peak_valid  = pv_q;
  assign bus.peak_amp    = amp_q;
  assign bus.rr_interval = rr_q;
  assign bus.rr_first    = rrf_q;
  assign bus.threshold   = thr_q;
  assign bus.busy        = (state_q != S_SEARCH);
endmodule

// File: tb/tb_ecg_peak_detector.sv
// Self-checking bench for ecg_peak_detector: directed scenarios plus random
// traffic compared against an index-based behavioural model of peak detection.
module tb_ecg_peak_detector;
  localparam int MAXW = 32;
  localparam int REFR = 72;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ecg_peak_detector_if #(.DATA_W(16), .RR_W(16)) bus ();

  ecg_peak_detector #(
    .DATA_W(16), .RR_W(16), .THRESH_INIT(2048), .MIN_THRESH(512),
    .REFRACT(REFR), .MAX_WIDTH(MAXW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: absolute sample indices since reset.
  int  m_n, m_trk, m_trk_start, m_mx, m_mx_idx, m_refr_end, m_last_peak;
  int  m_level, m_thr, m_amp, m_rr;
  bit  m_first, m_pulse;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rectify(input int s);
`ifdef ECG_PEAK_ABS_EN
    if (s == -32768) return 32767;
    return (s < 0) ? -s : s;
`else
    return s;
`endif
  endfunction

  task automatic model_reset();
    m_n = 0; m_trk = 0; m_trk_start = 0; m_mx = 0; m_mx_idx = 0;
    m_refr_end = 0; m_last_peak = -1; m_level = 4096; m_thr = 2048;
    m_amp = 0; m_rr = 0; m_first = 1'b1; m_pulse = 1'b0;
  endtask

  task automatic model_sample(input int s);
    int x;
    x = rectify(s);
    m_n++;
    m_pulse = 1'b0;
    if (m_n <= m_refr_end) begin
      // refractory: ignored
    end else if (m_trk != 0) begin
      if (x >= m_mx) begin
        if (m_n - m_trk_start == MAXW) m_trk = 0;
        else begin m_mx = x; m_mx_idx = m_n; end
      end else begin
        m_pulse = 1'b1;
        m_amp   = m_mx;
        m_first = (m_last_peak < 0);
        m_rr    = m_mx_idx - m_last_peak;
        m_last_peak = m_mx_idx;
        m_level = m_level - (m_level >>> 3) + (m_mx >>> 3);
        m_thr   = ((m_level >>> 1) < 512) ? 512 : (m_level >>> 1);
        m_refr_end = m_n + REFR;
        m_trk = 0;
      end
    end else if (x > m_thr) begin
      m_trk = 1; m_trk_start = m_n; m_mx = x; m_mx_idx = m_n;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".peak_valid"}, bus.peak_valid, m_pulse);
    chk({tag, ".peak_amp"},   bus.peak_amp,   m_amp);
    chk({tag, ".rr_first"},   bus.rr_first,   m_first);
    chk({tag, ".threshold"},  bus.threshold,  m_thr);
    chk({tag, ".busy"},       bus.busy, (m_trk != 0) || (m_n < m_refr_end));
    if (m_pulse && !m_first) chk({tag, ".rr_interval"}, bus.rr_interval, m_rr);
  endtask

  task automatic step(input int s, input bit v, input string tag);
    @(negedge clk);
    bus.sample_in    = 16'(s);
    bus.sample_valid = v;
    if (v) model_sample(s);
    else   m_pulse = 1'b0;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b0;
    bus.sample_valid = 1'b0;
    model_reset();
    #1;
    chk({tag, ".rst_peak_valid"}, bus.peak_valid, 0);
    chk({tag, ".rst_peak_amp"},   bus.peak_amp, 0);
    chk({tag, ".rst_rr"},         bus.rr_interval, 0);
    chk({tag, ".rst_rr_first"},   bus.rr_first, 1);
    chk({tag, ".rst_threshold"},  bus.threshold, 2048);
    chk({tag, ".rst_busy"},       bus.busy, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int tp1 [6] = '{0, 1000, 3000, 5000, 4000, 0};
    int r, s;
    bus.sample_in = '0;
    bus.sample_valid = 1'b0;
    model_reset();

    do_reset("init");

    // First peak: pulse on the 4000 sample
    foreach (tp1[i]) begin
      step(tp1[i], 1'b1, "tp1");
      if (i == 4) begin
        chk("tp1.pulse",     bus.peak_valid, 1);
        chk("tp1.amp",       bus.peak_amp, 5000);
        chk("tp1.first",     bus.rr_first, 1);
        chk("tp1.threshold", bus.threshold, 2104);
      end
    end

    // Second peak 300 samples after the first max (index 4), with valid gaps
    while (m_n < 302) begin
      step(0, 1'b1, "gap1");
      if (m_n % 50 == 0) step(9000, 1'b0, "hold");
    end
    step(3000, 1'b1, "pk2");
    step(5000, 1'b1, "pk2");
    step(0, 1'b1, "pk2");
    chk("pk2.pulse", bus.peak_valid, 1);
    chk("pk2.rr",    bus.rr_interval, 300);
    chk("pk2.first", bus.rr_first, 0);

    // Crossing 40 samples into refractory is ignored, at 100 it is detected
    r = m_n;
    while (m_n < r + 39) step(0, 1'b1, "refr");
    step(6000, 1'b1, "refr40");
    chk("refr40.busy", bus.busy, 1);
    step(0, 1'b1, "refr40");
    chk("refr40.nopulse", bus.peak_valid, 0);
    while (m_n < r + 99) step(0, 1'b1, "refr");
    step(6000, 1'b1, "refr100");
    step(0, 1'b1, "refr100");
    chk("refr100.pulse", bus.peak_valid, 1);
    chk("refr100.amp",   bus.peak_amp, 6000);

    // Plateau keeps the latest index
    for (int i = 0; i < REFR + 2; i++) step(0, 1'b1, "pre_plat");
    r = m_last_peak;
    step(5000, 1'b1, "plat");
    step(5000, 1'b1, "plat");
    step(5000, 1'b1, "plat");
    s = m_n;
    step(100, 1'b1, "plat");
    chk("plat.pulse", bus.peak_valid, 1);
    chk("plat.amp",   bus.peak_amp, 5000);
    chk("plat.rr",    bus.rr_interval, s - r);
    step(0, 1'b1, "plat");
    chk("plat.single", bus.peak_valid, 0);

    // Width abort: no pulse, threshold stays at reset value; then reset mid-TRACK
    do_reset("abort");
    for (int i = 0; i < 40; i++) step(4000, 1'b1, "abort");
    chk("abort.threshold", bus.threshold, 2048);
    chk("abort.busy", bus.busy, 1);
    do_reset("midtrack");

    // Inverted-lead peak
    step(0, 1'b1, "neg");
    step(-3000, 1'b1, "neg");
    step(-5000, 1'b1, "neg");
    step(-4000, 1'b1, "neg");
`ifdef ECG_PEAK_ABS_EN
    chk("neg.pulse", bus.peak_valid, 1);
    chk("neg.amp", bus.peak_amp, 5000);
`else
    chk("neg.nopulse", bus.peak_valid, 0);
`endif

    // Random traffic, including a mid-stream reset and full-scale negatives
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 6)       s = int'($urandom_range(0, 65535)) - 32768;
      else if (r < 8)  s = -32768;
      else if (r < 14) s = int'($urandom_range(2500, 9000));
      else             s = int'($urandom_range(0, 3000)) - 1500;
      step(s, ($urandom_range(0, 9) < 8), "rand");
      if (i == 700) do_reset("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
